cache_cmd_issuer: RTL and testbench
===================================

Name: cache_cmd_issuer

Overview:
- Producer end of the cache command interface: accepts 41-bit trace commands from the trace reader, buffers them in a small FIFO, and issues them to the cache one at a time under a valid/ready handshake.
- Decodes the 4-bit command code to keep per-class statistics and drop illegal codes.
- Enforces a post-clear stall so that a clear (n=8) completes before any following traffic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CMD_W, 41, command width; fixed layout n[40:37], address[36:5], aux3[4:2], aux2[1:0].
- HOLD_CYCLES, 4, cycles out_valid is forced low after a clear is issued; minimum 1.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream command valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_cmd  in  CMD_W  upstream command word.
- out_valid  out  1  command presented to the cache.
- out_ready  in  1  cache accepts the command.
- out_cmd  out  CMD_W  command to the cache, bit-identical to the accepted in_cmd.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- cnt_read  out  32  issued n=0 or n=2.
- cnt_write  out  32  issued n=1.
- cnt_snoop  out  32  issued n=3,4,5,6.
- cnt_drop  out  32  illegal codes discarded.

Behaviour:
- Reset (rst_n=0 at an edge): FIFO empty, pointers 0, level=0, in_ready=1, out_valid=0, out_cmd=0, all counters 0, state=IDLE. A mid-operation reset discards buffered commands and any pending hold.
- Push: occurs when in_valid && in_ready. Legal codes are {0..6,8,9}. Any other code is not stored; cnt_drop increments in the same cycle.
- FIFO: write and read pointers carry one extra wrap bit; full = (lower bits equal && wrap bits differ). Simultaneous push and pop is legal whenever in_ready=1, and level is unchanged. No push occurs when full.
- Latency: minimum 1 cycle. A command pushed into an empty FIFO at edge k drives out_valid=1 after edge k. There is no combinational in->out bypass.
- Handshake: out_cmd and out_valid hold stable while out_valid && !out_ready. The pop happens on out_valid && out_ready.
- FSM:
  - IDLE: FIFO empty, out_valid=0. Goes to ISSUE when level>0.
  - ISSUE: out_valid=1, head presented.
    - On handshake of n=8: all counters clear to 0 (the clear itself is not counted); go to HOLD with hold_cnt=HOLD_CYCLES-1.
    - On handshake of any other code: the relevant counter increments (n=9 increments none). Stay in ISSUE if level after pop >0, else go to IDLE.
  - HOLD: out_valid=0; pushes are still accepted; hold_cnt decrements. At 0, go to ISSUE if level>0, else IDLE.
- Counters wrap modulo 2^32.
- A drop in the same cycle as an n=8 issue: the clear wins and cnt_drop=0 afterwards.

Optional Feature:
- CMD_LOG_EN defined: each issue handshake emits $display of time, n, address and the four counters.
- Each drop emits a warning with the offending code.
- Undefined: no simulation output; RTL is otherwise identical.

Test Plan:
- Reset, then push n=0 addr 0x12345678 with out_ready=1 -> out_valid on the next cycle with out_cmd identical; cnt_read=1, level returns 0.
- out_ready=0, push 8 commands -> level=8, in_ready=0; a 9th push is refused. Raise out_ready -> 8 issues in order, one per cycle, pointers wrap correctly.
- Push n=1, n=8, n=3 with out_ready=1 -> cnt_write=1, then all counters 0 after the clear; out_valid low for exactly 4 cycles; then n=3 issues and cnt_snoop=1.
- Push n=7 and n=15 -> neither is ever issued; cnt_drop=2, level=0.
- Continuous push and pop every cycle for 20 cycles at level=3 -> level stays 3, counts match the issued codes.
- Assert rst_n=0 during HOLD with 5 entries queued -> next cycle level=0, out_valid=0, counters 0, state IDLE.

Source files
------------

// File: rtl/cache_cmd_issuer_if.sv
// Command bus between the trace reader, the issuer and the cache: an upstream
// push channel and a downstream issue channel, both valid/ready.
interface cache_cmd_issuer_if #(
  parameter int CMD_W = 41
);
  logic             in_valid;
  logic             in_ready;
  logic [CMD_W-1:0] in_cmd;
  logic             out_valid;
  logic             out_ready;
  logic [CMD_W-1:0] out_cmd;

  modport master (
    output in_valid, in_cmd, out_ready,
    input  in_ready, out_valid, out_cmd
  );

  modport slave (
    input  in_valid, in_cmd, out_ready,
    output in_ready, out_valid, out_cmd
  );
endinterface

// File: rtl/cache_cmd_issuer.sv
// Buffers trace commands in a FIFO and issues them to the cache with per-class
// statistics and a post-clear stall. Define CMD_LOG_EN for a simulation issue log.
module cache_cmd_issuer #(
  parameter int DEPTH       = 8,
  parameter int CMD_W       = 41,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cache_cmd_issuer_if.slave      bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            cnt_read,
  output logic [31:0]            cnt_write,
  output logic [31:0]            cnt_snoop,
  output logic [31:0]            cnt_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [HW-1:0]    r_hold_cnt, w_hold_nxt;
  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [31:0]      r_cnt_read, r_cnt_write, r_cnt_snoop, r_cnt_drop;

  logic             w_full, w_push, w_legal, w_store, w_drop, w_pop, w_clear;
  logic [3:0]       w_in_code, w_head_code;
  logic [CMD_W-1:0] w_head;
  logic [AW:0]      w_level, w_level_nxt;

  assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_level     = r_wr_ptr - r_rd_ptr;
  assign w_in_code   = bus.in_cmd[CMD_W-1 -: 4];
  assign w_legal     = (w_in_code <= 4'd6) || (w_in_code == 4'd8) || (w_in_code == 4'd9);
  assign w_push      = bus.in_valid && !w_full;
  assign w_store     = w_push && w_legal;
  assign w_drop      = w_push && !w_legal;
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_code = w_head[CMD_W-1 -: 4];
  assign w_pop       = (r_state == ISSUE) && bus.out_ready;
  assign w_clear     = w_pop && (w_head_code == 4'd8);
  // Occupancy after this edge; lets a push into an empty FIFO go valid one cycle later.
  assign w_level_nxt = w_level + {{AW{1'b0}}, w_store} - {{AW{1'b0}}, w_pop};

  assign bus.in_ready = !w_full;
  assign level        = w_level;
  assign cnt_read     = r_cnt_read;
  assign cnt_write    = r_cnt_write;
  assign cnt_snoop    = r_cnt_snoop;
  assign cnt_drop     = r_cnt_drop;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    bus.out_valid = 1'b0;
    bus.out_cmd   = '0;
    case (r_state)
      IDLE: begin
        if (w_level_nxt != '0) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.out_valid = 1'b1;
        bus.out_cmd   = w_head;
        if (w_clear) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = HW'(HOLD_CYCLES - 1);
        end else if (w_pop && (w_level_nxt == '0)) begin
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (r_hold_cnt == '0) begin
          w_state_nxt = (w_level_nxt != '0) ? ISSUE : IDLE;
        end else begin
          w_hold_nxt = r_hold_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr[AW-1:0]] <= bus.in_cmd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_cnt_read  <= '0;
      r_cnt_write <= '0;
      r_cnt_snoop <= '0;
      r_cnt_drop  <= '0;
    end else begin
      if (w_pop) begin
        case (w_head_code)
          4'd0, 4'd2:             r_cnt_read  <= r_cnt_read + 1'b1;
          4'd1:                   r_cnt_write <= r_cnt_write + 1'b1;
          4'd3, 4'd4, 4'd5, 4'd6: r_cnt_snoop <= r_cnt_snoop + 1'b1;
          default: ;
        endcase
      end
      if (w_drop) r_cnt_drop <= r_cnt_drop + 1'b1;
    end
  end

`ifdef CMD_LOG_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_pop)
        $display("[%0t] issue n=%0d addr=0x%08h read=%0d write=%0d snoop=%0d drop=%0d",
                 $time, w_head_code, w_head[36:5], r_cnt_read, r_cnt_write,
                 r_cnt_snoop, r_cnt_drop);
      if (w_drop)
        $display("[%0t] warning: dropped illegal command code %0d", $time, w_in_code);
    end
  end
`else
  // Logging compiled out; the datapath is identical.
`endif

endmodule

// File: tb/tb_cache_cmd_issuer.sv
// Directed bench for cache_cmd_issuer: a queue-based model checked every cycle,
// plus literal checkpoints for each scenario.
module tb_cache_cmd_issuer;
  localparam int DEPTH = 8;
  localparam int CMD_W = 41;
  localparam int HOLD  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  level;
  logic [31:0] cnt_read, cnt_write, cnt_snoop, cnt_drop;

  cache_cmd_issuer_if #(.CMD_W(CMD_W)) bus ();

  cache_cmd_issuer #(.DEPTH(DEPTH), .CMD_W(CMD_W), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .level     (level),
    .cnt_read  (cnt_read),
    .cnt_write (cnt_write),
    .cnt_snoop (cnt_snoop),
    .cnt_drop  (cnt_drop)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(input logic [3:0] n, input logic [31:0] addr);
    return {n, addr, 3'b000, 2'b00};
  endfunction

  // Reference model: pending commands in a queue, remaining stall cycles, counters.
  logic [CMD_W-1:0] m_q[$];
  int               m_hold = 0;
  logic [31:0]      m_rd = 0, m_wr = 0, m_sn = 0, m_dr = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_hold = 0;
      m_rd = 0; m_wr = 0; m_sn = 0; m_dr = 0;
    end else begin
      bit               ov, rdy, push, pop, legal, clr;
      logic [3:0]       code, hcode;
      logic [CMD_W-1:0] head;
      ov    = (m_hold == 0) && (m_q.size() > 0);
      rdy   = m_q.size() < DEPTH;
      code  = bus.in_cmd[40:37];
      legal = (code <= 6) || (code == 8) || (code == 9);
      push  = bus.in_valid && rdy;
      pop   = ov && bus.out_ready;
      clr   = 1'b0;
      if (m_hold > 0) m_hold--;
      if (pop) begin
        head  = m_q.pop_front();
        hcode = head[40:37];
        if (hcode == 8) begin
          clr = 1'b1;
          m_rd = 0; m_wr = 0; m_sn = 0; m_dr = 0;
          m_hold = HOLD;
        end else if (hcode == 0 || hcode == 2) m_rd++;
        else if (hcode == 1) m_wr++;
        else if (hcode >= 3 && hcode <= 6) m_sn++;
      end
      if (push && !legal && !clr) m_dr++;
      if (push && legal) m_q.push_back(bus.in_cmd);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_ov;
      exp_ov = (m_hold == 0) && (m_q.size() > 0);
      check("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_ov});
      if (exp_ov) check("out_cmd", 64'(bus.out_cmd), 64'(m_q[0]));
      check("in_ready", {63'd0, bus.in_ready}, {63'd0, m_q.size() < DEPTH});
      check("level", 64'(level), 64'(m_q.size()));
      check("cnt_read", 64'(cnt_read), 64'(m_rd));
      check("cnt_write", 64'(cnt_write), 64'(m_wr));
      check("cnt_snoop", 64'(cnt_snoop), 64'(m_sn));
      check("cnt_drop", 64'(cnt_drop), 64'(m_dr));
    end
  end

  task automatic push(input logic [CMD_W-1:0] c);
    bus.in_valid = 1'b1;
    bus.in_cmd   = c;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes [8];
    int lows;
    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9};
    bus.in_valid  = 1'b0;
    bus.in_cmd    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    check("rst_level", 64'(level), 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_cmd", 64'(bus.out_cmd), 64'd0);
    check("rst_cnt_read", 64'(cnt_read), 64'd0);

    // Single read: one-cycle latency, bit-identical command
    push(mk(4'd0, 32'h1234_5678));
    check("t1_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t1_cmd", 64'(bus.out_cmd), 64'h0000_0002_468A_CF00);
    @(negedge clk);
    check("t1_cnt_read", 64'(cnt_read), 64'd1);
    check("t1_level", 64'(level), 64'd0);

    // Fill to full with the cache stalled, refuse a ninth, then drain in order
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(mk(codes[i], 32'h100 + 32'(i)));
    check("t2_full_level", 64'(level), 64'd8);
    check("t2_full_ready", {63'd0, bus.in_ready}, 64'd0);
    push(mk(4'd1, 32'hDEAD));
    check("t2_refused", 64'(level), 64'd8);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("t2_drained", 64'(level), 64'd0);
    check("t2_read", 64'(cnt_read), 64'd3);
    check("t2_write", 64'(cnt_write), 64'd1);
    check("t2_snoop", 64'(cnt_snoop), 64'd4);

    // Clear followed by a snoop: four stalled cycles, counters zeroed
    push(mk(4'd1, 32'hA));
    push(mk(4'd8, 32'hB));
    push(mk(4'd3, 32'hC));
    lows = 0;
    while (bus.out_valid !== 1'b1 && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    check("t3_hold_len", 64'(lows), 64'd4);
    check("t3_write_cleared", 64'(cnt_write), 64'd0);
    check("t3_read_cleared", 64'(cnt_read), 64'd0);
    @(negedge clk);
    check("t3_snoop", 64'(cnt_snoop), 64'd1);

    // Illegal codes are dropped and never issued
    push(mk(4'd7, 32'h77));
    push(mk(4'd15, 32'hFF));
    @(negedge clk);
    check("t4_drop", 64'(cnt_drop), 64'd2);
    check("t4_level", 64'(level), 64'd0);
    check("t4_valid", {63'd0, bus.out_valid}, 64'd0);

    // Steady streaming at level 3
    bus.out_ready = 1'b0;
    push(mk(4'd0, 32'h200));
    push(mk(4'd1, 32'h201));
    push(mk(4'd3, 32'h202));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_cmd   = mk(codes[i % 8], 32'h300 + 32'(i));
      @(negedge clk);
      check("t5_level", 64'(level), 64'd3);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("t5_read", 64'(cnt_read), 64'd7);
    check("t5_write", 64'(cnt_write), 64'd4);
    check("t5_snoop", 64'(cnt_snoop), 64'd11);
    check("t5_drop", 64'(cnt_drop), 64'd2);

    // Reset during the post-clear stall with five commands queued
    bus.out_ready = 1'b0;
    push(mk(4'd8, 32'h400));
    for (int i = 0; i < 5; i++) push(mk(4'd2, 32'h401 + 32'(i)));
    check("t6_level_pre", 64'(level), 64'd6);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t6_in_hold", {63'd0, bus.out_valid}, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_level", 64'(level), 64'd0);
    check("t6_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t6_cnt_read", 64'(cnt_read), 64'd0);
    check("t6_cnt_drop", 64'(cnt_drop), 64'd0);
    push(mk(4'd1, 32'h500));
    check("t6_no_stale_hold", {63'd0, bus.out_valid}, 64'd1);
    @(negedge clk);
    check("t6_write", 64'(cnt_write), 64'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
